mem_arbiter: RTL and testbench

- Shares the single 16-bit external SRAM port between instruction fetch (IF stage) and data access (MEM stage).
- Data accesses take priority. While one is in progress, the block asserts stall_pc_o to the fetch unit and feeds a NOP into IF/ID.
- It sequences the SRAM control strobes: 1-cycle reads, multi-cycle setup/strobe/hold writes.
- It sits between ifetch, the MEM stage and the board RAM pins.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding and the
// NOP instruction word (also consumed by the decoder).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WR_SETUP  = 2'd1,
        WR_STROBE = 2'd2,
        WR_HOLD   = 2'd3
    } arb_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single external SRAM port between instruction fetch and MEM-stage
// data accesses; data wins, fetch is stalled and a NOP is fed to IF/ID.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// FETCH     | fetch from if_addr_i, or 1-cycle data read, or accept a write
// WR_SETUP  | latched address/data on the bus, data driven, we_n high
// WR_STROBE | we_n low for STROBE_CYCLES cycles
// WR_HOLD   | we_n high, address/data held; pulse mem_done_o, back to FETCH
module mem_arbiter #(
    parameter logic [15:0] NOP_INSTR     = mem_arbiter_pkg::NOP_INSTR,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] if_addr_i,
    output logic [15:0] instr_o,
    output logic        instr_valid_o,
    output logic        stall_pc_o,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_wdata_i,
    output logic [15:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic [15:0] ram_addr_o,
    output logic [15:0] ram_wdata_o,
    output logic        ram_data_oe_o,
    input  logic [15:0] ram_rdata_i,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o
);
    import mem_arbiter_pkg::*;

    localparam logic [1:0] STROBE_LOAD = 2'(STROBE_CYCLES - 1);

    arb_state_e  r_state;
    logic [1:0]  r_strobe_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_instr;
    logic        r_instr_valid;
    logic [15:0] r_mem_rdata;
    logic        r_mem_done;

    logic        w_accept;
    logic        w_wr_acc;
    logic        w_rd_acc;

    // The done cycle always falls through to a fetch, so a held request
    // cannot starve the instruction stream.
    assign w_accept = (r_state == FETCH) && !r_mem_done;
    assign w_wr_acc = w_accept && mem_wr_i;
    assign w_rd_acc = w_accept && !mem_wr_i && mem_rd_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= FETCH;
            r_strobe_cnt  <= 2'd0;
            r_addr        <= 16'h0000;
            r_wdata       <= 16'h0000;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_mem_rdata   <= 16'h0000;
            r_mem_done    <= 1'b0;
        end else begin
            r_mem_done <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (w_wr_acc) begin
                        r_addr        <= mem_addr_i;
                        r_wdata       <= mem_wdata_i;
                        r_instr       <= NOP_INSTR;
                        r_instr_valid <= 1'b0;
                        r_state       <= WR_SETUP;
                    end else if (w_rd_acc) begin
                        r_mem_rdata   <= ram_rdata_i;
                        r_mem_done    <= 1'b1;
                        r_instr       <= NOP_INSTR;
                        r_instr_valid <= 1'b0;
                    end else begin
                        r_instr       <= ram_rdata_i;
                        r_instr_valid <= 1'b1;
                    end
                end
                WR_SETUP: begin
                    r_strobe_cnt <= STROBE_LOAD;
                    r_state      <= WR_STROBE;
                end
                WR_STROBE: begin
                    if (r_strobe_cnt == 2'd0) begin
                        r_state <= WR_HOLD;
                    end else begin
                        r_strobe_cnt <= r_strobe_cnt - 2'd1;
                    end
                end
                WR_HOLD: begin
                    r_mem_done <= 1'b1;
                    r_state    <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // SRAM strobes are combinational so reset can idle them in the same cycle.
    always_comb begin
        ram_addr_o    = if_addr_i;
        ram_wdata_o   = r_wdata;
        ram_data_oe_o = 1'b0;
        ram_oe_n_o    = 1'b1;
        ram_we_n_o    = 1'b1;
        stall_pc_o    = 1'b0;
        case (r_state)
            FETCH: begin
                if (w_wr_acc) begin
                    ram_addr_o = mem_addr_i;
                    stall_pc_o = 1'b1;
                end else if (w_rd_acc) begin
                    ram_addr_o = mem_addr_i;
                    ram_oe_n_o = 1'b0;
                    stall_pc_o = 1'b1;
                end else begin
                    ram_oe_n_o = 1'b0;
                end
            end
            WR_SETUP, WR_HOLD: begin
                ram_addr_o    = r_addr;
                ram_data_oe_o = 1'b1;
                stall_pc_o    = 1'b1;
            end
            WR_STROBE: begin
                ram_addr_o    = r_addr;
                ram_data_oe_o = 1'b1;
                ram_we_n_o    = 1'b0;
                stall_pc_o    = 1'b1;
            end
            default: begin
                ram_addr_o = if_addr_i;
            end
        endcase
        if (RST) begin
            ram_data_oe_o = 1'b0;
            ram_oe_n_o    = 1'b1;
            ram_we_n_o    = 1'b1;
            stall_pc_o    = 1'b0;
        end
    end

    assign instr_o       = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign mem_rdata_o   = r_mem_rdata;
    assign mem_done_o    = r_mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STROBE_CYCLES = 1).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] if_addr_i;
    logic [15:0] instr_o;
    logic        instr_valid_o;
    logic        stall_pc_o;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [15:0] mem_addr_i;
    logic [15:0] mem_wdata_i;
    logic [15:0] mem_rdata_o;
    logic        mem_done_o;
    logic [15:0] ram_addr_o;
    logic [15:0] ram_wdata_o;
    logic        ram_data_oe_o;
    logic [15:0] ram_rdata_i;
    logic        ram_oe_n_o;
    logic        ram_we_n_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STROBE_CYCLES(1)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .if_addr_i     (if_addr_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .stall_pc_o    (stall_pc_o),
        .mem_rd_i      (mem_rd_i),
        .mem_wr_i      (mem_wr_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_done_o    (mem_done_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_data_oe_o (ram_data_oe_o),
        .ram_rdata_i   (ram_rdata_i),
        .ram_oe_n_o    (ram_oe_n_o),
        .ram_we_n_o    (ram_we_n_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    int stall_cnt;
    int we_cnt;
    int done_cnt;
    int both_low;
    logic [15:0] exp_addr [4];
    logic        exp_done [4];

    initial begin
        RST         = 1'b1;
        if_addr_i   = 16'h0000;
        mem_rd_i    = 1'b0;
        mem_wr_i    = 1'b0;
        mem_addr_i  = 16'h0000;
        mem_wdata_i = 16'h0000;
        ram_rdata_i = 16'h0000;

        // reset: strobes idle during the reset cycle, registers at reset values
        @(negedge CLK);
        chk_val("rst_oe_n",    32'(ram_oe_n_o),    32'd1);
        chk_val("rst_we_n",    32'(ram_we_n_o),    32'd1);
        chk_val("rst_data_oe", 32'(ram_data_oe_o), 32'd0);
        chk_val("rst_stall",   32'(stall_pc_o),    32'd0);
        next_edge();
        next_edge();
        chk_val("rst_instr",   32'(instr_o),       32'h0800);
        chk_val("rst_valid",   32'(instr_valid_o), 32'd0);
        chk_val("rst_rdata",   32'(mem_rdata_o),   32'd0);
        chk_val("rst_done",    32'(mem_done_o),    32'd0);

        // plain fetch
        RST         = 1'b0;
        if_addr_i   = 16'h0000;
        ram_rdata_i = 16'h6801;
        @(negedge CLK);
        chk_val("f_addr",  32'(ram_addr_o), 32'h0000);
        chk_val("f_oe_n",  32'(ram_oe_n_o), 32'd0);
        chk_val("f_we_n",  32'(ram_we_n_o), 32'd1);
        chk_val("f_stall", 32'(stall_pc_o), 32'd0);
        next_edge();
        chk_val("f_instr", 32'(instr_o),       32'h6801);
        chk_val("f_valid", 32'(instr_valid_o), 32'd1);

        // single data read
        mem_rd_i    = 1'b1;
        mem_addr_i  = 16'h8000;
        ram_rdata_i = 16'hBEEF;
        @(negedge CLK);
        chk_val("rd_addr",  32'(ram_addr_o), 32'h8000);
        chk_val("rd_stall", 32'(stall_pc_o), 32'd1);
        chk_val("rd_oe_n",  32'(ram_oe_n_o), 32'd0);
        next_edge();
        chk_val("rd_rdata", 32'(mem_rdata_o),   32'hBEEF);
        chk_val("rd_done",  32'(mem_done_o),    32'd1);
        chk_val("rd_instr", 32'(instr_o),       32'h0800);
        chk_val("rd_valid", 32'(instr_valid_o), 32'd0);
        mem_rd_i    = 1'b0;
        if_addr_i   = 16'h0002;
        ram_rdata_i = 16'h1111;
        @(negedge CLK);
        chk_val("rd_f_addr",  32'(ram_addr_o), 32'h0002);
        chk_val("rd_f_stall", 32'(stall_pc_o), 32'd0);
        next_edge();
        chk_val("rd_f_instr", 32'(instr_o),    32'h1111);
        chk_val("rd_f_done",  32'(mem_done_o), 32'd0);

        // write, request dropped and inputs scrambled after acceptance
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h8001;
        mem_wdata_i = 16'h1234;
        if_addr_i   = 16'h0004;
        ram_rdata_i = 16'h2222;
        stall_cnt = 0; we_cnt = 0; done_cnt = 0; both_low = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (!ram_oe_n_o && !ram_we_n_o) both_low++;
            if (stall_pc_o) stall_cnt++;
            if (i == 0) begin
                chk_val("wr_acc_oe_n", 32'(ram_oe_n_o),    32'd1);
                chk_val("wr_acc_we_n", 32'(ram_we_n_o),    32'd1);
                chk_val("wr_acc_doe",  32'(ram_data_oe_o), 32'd0);
            end
            if (!ram_we_n_o) begin
                we_cnt++;
                chk_val("wr_addr",  32'(ram_addr_o),    32'h8001);
                chk_val("wr_wdata", 32'(ram_wdata_o),   32'h1234);
                chk_val("wr_doe",   32'(ram_data_oe_o), 32'd1);
            end
            next_edge();
            if (mem_done_o) done_cnt++;
            if (i == 0) begin
                chk_val("wr_nop_instr", 32'(instr_o),       32'h0800);
                chk_val("wr_nop_valid", 32'(instr_valid_o), 32'd0);
                mem_wr_i    = 1'b0;
                mem_addr_i  = 16'hDEAD;
                mem_wdata_i = 16'h5555;
            end
        end
        chk_val("wr_stall_cycles", 32'(stall_cnt), 32'd4);
        chk_val("wr_we_cycles",    32'(we_cnt),    32'd1);
        chk_val("wr_done_pulses",  32'(done_cnt),  32'd1);
        chk_val("wr_both_low",     32'(both_low),  32'd0);
        chk_val("wr_after_instr",  32'(instr_o),   32'h2222);

        // held read: read / fetch / read / fetch
        mem_rd_i    = 1'b1;
        mem_addr_i  = 16'h9000;
        if_addr_i   = 16'h0010;
        ram_rdata_i = 16'hA5A5;
        exp_addr = '{16'h9000, 16'h0010, 16'h9000, 16'h0010};
        exp_done = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk_val($sformatf("hold_addr%0d", i), 32'(ram_addr_o), 32'(exp_addr[i]));
            chk_val($sformatf("hold_stall%0d", i), 32'(stall_pc_o), 32'(exp_done[i]));
            next_edge();
            chk_val($sformatf("hold_done%0d", i), 32'(mem_done_o), 32'(exp_done[i]));
        end
        mem_rd_i = 1'b0;
        chk_val("hold_rdata", 32'(mem_rdata_o), 32'hA5A5);

        // reset while in WR_STROBE aborts the write
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h8002;
        mem_wdata_i = 16'h7777;
        next_edge();
        mem_wr_i = 1'b0;
        next_edge();
        RST = 1'b1;
        @(negedge CLK);
        chk_val("rstw_we_n", 32'(ram_we_n_o),    32'd1);
        chk_val("rstw_oe_n", 32'(ram_oe_n_o),    32'd1);
        chk_val("rstw_doe",  32'(ram_data_oe_o), 32'd0);
        next_edge();
        chk_val("rstw_done", 32'(mem_done_o), 32'd0);
        RST         = 1'b0;
        if_addr_i   = 16'h0020;
        ram_rdata_i = 16'h4321;
        @(negedge CLK);
        chk_val("rstw_f_addr",  32'(ram_addr_o), 32'h0020);
        chk_val("rstw_f_oe_n",  32'(ram_oe_n_o), 32'd0);
        chk_val("rstw_f_we_n",  32'(ram_we_n_o), 32'd1);
        chk_val("rstw_f_stall", 32'(stall_pc_o), 32'd0);
        next_edge();
        chk_val("rstw_f_instr", 32'(instr_o),       32'h4321);
        chk_val("rstw_f_valid", 32'(instr_valid_o), 32'd1);
        chk_val("rstw_f_done",  32'(mem_done_o),    32'd0);
        chk_val("rstw_rdata",   32'(mem_rdata_o),   32'h0000);

        // read and write together: write wins, no read data captured
        mem_rd_i    = 1'b1;
        mem_wr_i    = 1'b1;
        mem_addr_i  = 16'h8003;
        mem_wdata_i = 16'hCAFE;
        ram_rdata_i = 16'h9999;
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 0) chk_val("rw_acc_oe_n", 32'(ram_oe_n_o), 32'd1);
            if (!ram_we_n_o) begin
                we_cnt++;
                chk_val("rw_addr",  32'(ram_addr_o),  32'h8003);
                chk_val("rw_wdata", 32'(ram_wdata_o), 32'hCAFE);
            end
            next_edge();
            if (mem_done_o) done_cnt++;
            if (i == 0) begin
                mem_rd_i = 1'b0;
                mem_wr_i = 1'b0;
            end
        end
        chk_val("rw_we_cycles", 32'(we_cnt),      32'd1);
        chk_val("rw_done",      32'(done_cnt),    32'd1);
        chk_val("rw_rdata",     32'(mem_rdata_o), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
